// File: rtl/seg_display_pkg.sv
// Shared glyph codes and the active-low seven-segment decode used by the
// display controller.
package seg_display_pkg;

  localparam logic [4:0] GLYPH_R          = 5'd16;
  localparam logic [4:0] GLYPH_D          = 5'd17;
  localparam logic [4:0] GLYPH_T          = 5'd18;
  localparam logic [4:0] GLYPH_UNDERSCORE = 5'd19;
  localparam logic [4:0] GLYPH_DASH       = 5'd20;
  localparam logic [4:0] GLYPH_N          = 5'd21;
  localparam logic [4:0] GLYPH_BLANK      = 5'd31;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Bit 7 is DP, bits 6:0 are g..a; all active low.
  function automatic logic [7:0] seg_decode(input logic [4:0] code, input logic dp);
    logic [7:0] pat;
    case (code)
      5'd0:             pat = 8'hC0;
      5'd1:             pat = 8'hF9;
      5'd2:             pat = 8'hA4;
      5'd3:             pat = 8'hB0;
      5'd4:             pat = 8'h99;
      5'd5:             pat = 8'h92;
      5'd6:             pat = 8'h82;
      5'd7:             pat = 8'hF8;
      5'd8:             pat = 8'h80;
      5'd9:             pat = 8'h90;
      5'd10:            pat = 8'h88;
      5'd11:            pat = 8'h83;
      5'd12:            pat = 8'hC6;
      5'd13:            pat = 8'hA1;
      5'd14:            pat = 8'h86;
      5'd15:            pat = 8'h8E;
      GLYPH_R:          pat = 8'hAF;
      GLYPH_D:          pat = 8'hA1;
      GLYPH_T:          pat = 8'h87;
      GLYPH_UNDERSCORE: pat = 8'hF7;
      GLYPH_DASH:       pat = 8'hBF;
      GLYPH_N:          pat = 8'hAB;
      default:          pat = SEG_BLANK;
    endcase
    if (dp) pat[7] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/seg_display_digit.sv
// Per-digit combinational pattern: glyph decode, then leading-zero and blink
// masking.
module seg_display_digit
  import seg_display_pkg::*;
(
  input  logic [4:0] code,
  input  logic       dp,
  input  logic       suppress,
  input  logic       hide,
  output logic [7:0] seg
);

  always_comb begin
    seg = seg_decode(code, dp);
    // A suppressed leading zero keeps its decimal point.
    if (suppress) seg = {~dp, 7'h7F};
    if (hide)     seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: shadowed digit codes, leading-zero
// suppression, blink, and static plus scanned registered outputs.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] code_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lzs_en,
  output logic [8*NUM_DIGITS-1:0] seg_all,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    blink_phase
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [5*NUM_DIGITS-1:0] code_q, code_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [SW-1:0]           slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [8*NUM_DIGITS-1:0] seg_all_q, seg_all_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_run;
  logic                    slot_tc;
  logic [7:0]              digit_pat [NUM_DIGITS];

  always_comb begin
    code_d  = code_q;
    dp_d    = dp_q;
    blink_d = blink_q;
    if (load) begin
      code_d  = code_in;
      dp_d    = dp_in;
      blink_d = blink_in;
    end
  end

  // Zero run starts at the top digit; digit 0 never joins it.
  always_comb begin
    supp     = '0;
    zero_run = lzs_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (code_q[5*i +: 5] == 5'd0);
      supp[i]  = zero_run;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg_display_digit u_digit (
      .code     (code_q[5*g +: 5]),
      .dp       (dp_q[g]),
      .suppress (supp[g]),
      .hide     (blink_q[g] & ~blink_phase_q),
      .seg      (digit_pat[g])
    );
  end

  always_comb begin
    slot_tc       = (slot_cnt_q == SLOT_LAST);
    slot_cnt_d    = slot_tc ? '0 : slot_cnt_q + SW'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Slot count 0 is the anti-ghost guard: everything dark.
  always_comb begin
    seg_all_d = '0;
    an_d      = '1;
    seg_d     = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_all_d[8*i +: 8] = digit_pat[i];
      if (slot_cnt_q != '0 && idx_q == IW'(i)) begin
        an_d[i] = 1'b0;
        seg_d   = digit_pat[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q        <= {NUM_DIGITS{GLYPH_BLANK}};
      dp_q          <= '0;
      blink_q       <= '0;
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      seg_all_q     <= '1;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      code_q        <= code_d;
      dp_q          <= dp_d;
      blink_q       <= blink_d;
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_all_q     <= seg_all_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg_all     = seg_all_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with short scan/blink dividers.
module tb_seg_display_ctrl;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic [5*ND-1:0] code_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blink_in = '0;
  logic          lzs_en = 1'b0;
  logic [8*ND-1:0] seg_all;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic          blink_phase;

  int errors = 0;
  int checks = 0;

  logic [7:0] pats [ND];

  seg_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .code_in(code_in), .dp_in(dp_in),
    .blink_in(blink_in), .lzs_en(lzs_en), .seg_all(seg_all), .seg(seg),
    .an(an), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset;
    rst_n = 1'b0;
    load  = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick(2);
    checks++; if (seg_all !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL reset_seg_all got=%h exp=%h", seg_all, 48'hFFFF_FFFF_FFFF); end
    checks++; if (an !== 6'h3F) begin errors++; $display("FAIL reset_an got=%h exp=3f", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL reset_blink_phase got=%b exp=1", blink_phase); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (an !== 6'h3F) begin errors++; $display("FAIL reset_first_guard an got=%h exp=3f", an); end
    tick(1);
    checks++; if (an !== 6'h3E) begin errors++; $display("FAIL reset_first_idx0 an got=%h exp=3e", an); end
  endtask

  task automatic test_load;
    code_in  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp_in    = 6'b000001;
    blink_in = '0;
    lzs_en   = 1'b0;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (seg_all !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL load_latency got=%h exp=%h", seg_all, 48'hFFFF_FFFF_FFFF); end
    tick(1);
    checks++; if (seg_all !== 48'h9299_B0A4_F940) begin errors++; $display("FAIL load_hex got=%h exp=%h", seg_all, 48'h9299_B0A4_F940); end
    code_in = {5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8};
    dp_in   = '0;
    tick(3);
    checks++; if (seg_all !== 48'h9299_B0A4_F940) begin errors++; $display("FAIL shadow_hold got=%h exp=%h", seg_all, 48'h9299_B0A4_F940); end
  endtask

  task automatic test_lzs;
    code_in = {5'd0, 5'd0, 5'd0, 5'd10, 5'd0, 5'd7};
    dp_in   = '0;
    lzs_en  = 1'b1;
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    checks++; if (seg_all !== 48'hFFFF_FF88_C0F8) begin errors++; $display("FAIL lzs_on got=%h exp=%h", seg_all, 48'hFFFF_FF88_C0F8); end
    lzs_en = 1'b0;
    tick(1);
    checks++; if (seg_all !== 48'hC0C0_C088_C0F8) begin errors++; $display("FAIL lzs_off got=%h exp=%h", seg_all, 48'hC0C0_C088_C0F8); end
    code_in = '0;
    dp_in   = 6'b100000;
    lzs_en  = 1'b1;
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    checks++; if (seg_all !== 48'h7FFF_FFFF_FFC0) begin errors++; $display("FAIL lzs_all_zero got=%h exp=%h", seg_all, 48'h7FFF_FFFF_FFC0); end
    lzs_en = 1'b0;
  endtask

  task automatic test_glyphs;
    code_in = {5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
    dp_in   = '0;
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    checks++; if (seg_all !== 48'hAFA1_87F7_BFAB) begin errors++; $display("FAIL glyph_letters got=%h exp=%h", seg_all, 48'hAFA1_87F7_BFAB); end
    code_in = {5'd22, 5'd31, 5'd15, 5'd14, 5'd13, 5'd12};
    dp_in   = 6'b010000;
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    checks++; if (seg_all !== 48'hFF7F_8E86_A1C6) begin errors++; $display("FAIL glyph_blank_hex got=%h exp=%h", seg_all, 48'hFF7F_8E86_A1C6); end
  endtask

  // After release with load at edge 1, outputs after edge k show slot (k-1)%4
  // of digit ((k-1)/4)%6.
  task automatic test_scan;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    logic [5:0] onehot;
    int idx;
    pats[0] = 8'hC0; pats[1] = 8'hF9; pats[2] = 8'hA4;
    pats[3] = 8'hB0; pats[4] = 8'h99; pats[5] = 8'h92;
    hold_reset();
    code_in  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp_in    = '0;
    blink_in = '0;
    lzs_en   = 1'b0;
    rst_n    = 1'b1;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      if (k > 1) tick(1);
      idx = ((k - 1) / 4) % 6;
      onehot = 6'b000001 << idx;
      if ((k - 1) % 4 == 0) begin
        exp_an  = 6'h3F;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~onehot;
        exp_seg = pats[idx];
      end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, exp_seg); end
    end
  endtask

  // blink_phase flips every 2 slots = 8 cycles; seg_all follows one cycle later.
  task automatic test_blink;
    logic       exp_phase;
    logic [7:0] exp_d1;
    hold_reset();
    code_in  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp_in    = '0;
    blink_in = 6'b000010;
    rst_n    = 1'b1;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) tick(1);
      exp_phase = ((k / 8) % 2 == 0);
      checks++; if (blink_phase !== exp_phase) begin errors++; $display("FAIL blink_phase k=%0d got=%b exp=%b", k, blink_phase, exp_phase); end
      if (k >= 2) begin
        exp_d1 = (((k - 1) / 8) % 2 == 0) ? 8'hF9 : 8'hFF;
        checks++; if (seg_all[15:8] !== exp_d1) begin errors++; $display("FAIL blink_digit1 k=%0d got=%h exp=%h", k, seg_all[15:8], exp_d1); end
        checks++; if (seg_all[7:0] !== 8'hC0) begin errors++; $display("FAIL blink_digit0 k=%0d got=%h exp=c0", k, seg_all[7:0]); end
      end
    end
    blink_in = '0;
  endtask

  task automatic test_load_at_tc;
    hold_reset();
    code_in  = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp_in    = '0;
    blink_in = '0;
    rst_n    = 1'b1;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    code_in = {5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd7};
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (seg !== 8'hC0 || an !== 6'h3E) begin errors++; $display("FAIL tc_last_old got=%h/%h exp=c0/3e", seg, an); end
    tick(1);
    checks++; if (seg !== 8'hFF || an !== 6'h3F) begin errors++; $display("FAIL tc_guard got=%h/%h exp=ff/3f", seg, an); end
    tick(1);
    checks++; if (seg !== 8'h90 || an !== 6'h3D) begin errors++; $display("FAIL tc_new_data got=%h/%h exp=90/3d", seg, an); end
    code_in = {5'd9, 5'd9, 5'd9, 5'd9, 5'd8, 5'd7};
    load    = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (seg !== 8'h90 || an !== 6'h3D) begin errors++; $display("FAIL midslot_before got=%h/%h exp=90/3d", seg, an); end
    tick(1);
    checks++; if (seg !== 8'h80 || an !== 6'h3D) begin errors++; $display("FAIL midslot_after got=%h/%h exp=80/3d", seg, an); end
    tick(1);
    checks++; if (an !== 6'h3F) begin errors++; $display("FAIL midslot_next_guard an got=%h exp=3f", an); end
  endtask

  task automatic test_reset_mid;
    tick(2);
    checks++; if (seg !== 8'h90 || an !== 6'h3B) begin errors++; $display("FAIL pre_reset got=%h/%h exp=90/3b", seg, an); end
    rst_n = 1'b0;
    #1;
    checks++; if (seg_all !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL midreset_seg_all got=%h exp=%h", seg_all, 48'hFFFF_FFFF_FFFF); end
    checks++; if (seg !== 8'hFF || an !== 6'h3F) begin errors++; $display("FAIL midreset_scan got=%h/%h exp=ff/3f", seg, an); end
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("FAIL midreset_phase got=%b exp=1", blink_phase); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++; if (an !== 6'h3F) begin errors++; $display("FAIL midreset_guard an got=%h exp=3f", an); end
    tick(1);
    checks++; if (an !== 6'h3E || seg !== 8'hFF) begin errors++; $display("FAIL midreset_idx0 got=%h/%h exp=ff/3e", seg, an); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_lzs();
    test_glyphs();
    test_scan();
    test_blink();
    test_load_at_tc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
